// File: rtl/serial_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add : bit-serial LSB-first adder, one full-adder cell per clock    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;

  assign w_s        = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_c        = (r_sa[0] & r_sb[0]) | (r_sb[0] & r_carry) | (r_carry & r_sa[0]);
  // result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_res   <= w_res_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            sum   <= w_res_next;
            cout  <= w_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_add : randomized self-checking bench for serial_add (W=8, W=13) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_serial_add;

  logic        clk;
  logic        rst;
  logic        start8, cin8, cout8, busy8, done8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, cout13, busy13, done13;
  logic [12:0] a13, b13, sum13;

  int vectors;
  int miscompares;

  serial_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_add #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .sum(sum13), .cout(cout13), .busy(busy13), .done(done13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; lat = edges after the accepting edge until done is seen.
  task automatic run_op(input bit w13, input logic [12:0] av, input logic [12:0] bv,
                        input logic ci, output logic [12:0] s, output logic c,
                        output int lat, output int bc);
    @(negedge clk);
    if (w13) begin
      a13 = av; b13 = bv; cin13 = ci; start13 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; start8 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start13 = 1'b0;
    a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
    a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
    lat = -1;
    bc  = 0;
    if (w13 ? busy13 : busy8) bc++;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (w13 ? busy13 : busy8) bc++;
      if (w13 ? done13 : done8) lat = n;
    end
    s = w13 ? sum13 : {5'b0, sum8};
    c = w13 ? cout13 : cout8;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    a13 = '0; b13 = '0; cin13 = 1'b0; start13 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sum8, cout8, busy8, done8} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset8: got sum=%h cout=%b busy=%b done=%b expected all 0", sum8, cout8, busy8, done8);
    end
    vectors++;
    if ({sum13, cout13, busy13, done13} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset13: got sum=%h cout=%b busy=%b done=%b expected all 0", sum13, cout13, busy13, done13);
    end
    // start held through reset release is taken on the first edge with rst low
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    vectors++;
    if (busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL first_start: got busy=%b expected 1", busy8);
    end
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done8) lat = n;
    end
    vectors++;
    if (lat != 8 || sum8 !== 8'h07 || cout8 !== 1'b0) begin
      miscompares++;
      $display("FAIL first_op: got lat=%0d sum=%h cout=%b expected lat=8 sum=07 cout=0", lat, sum8, cout8);
    end
  endtask

  task automatic test_basic();
    logic [12:0] s; logic c; int lat, bc;
    run_op(1'b0, 13'h0F, 13'h01, 1'b0, s, c, lat, bc);
    vectors++;
    if (s[7:0] !== 8'h10 || c !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_sum: got %b_%h expected 0_10", c, s[7:0]);
    end
    // done seen after the 8th edge past acceptance, i.e. sampled on edge 9
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    vectors++;
    if (bc != 8) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d cycles expected 8", bc);
    end
  endtask

  task automatic test_carry();
    logic [12:0] s; logic c; int lat, bc;
    run_op(1'b0, 13'hFF, 13'h01, 1'b0, s, c, lat, bc);
    vectors++;
    if (s[7:0] !== 8'h00 || c !== 1'b1 || lat != 8) begin
      miscompares++;
      $display("FAIL carry_ff01: got %b_%h lat=%0d expected 1_00 lat=8", c, s[7:0], lat);
    end
    run_op(1'b0, 13'hFF, 13'hFF, 1'b1, s, c, lat, bc);
    vectors++;
    if (s[7:0] !== 8'hFF || c !== 1'b1 || lat != 8) begin
      miscompares++;
      $display("FAIL full_scale: got %b_%h lat=%0d expected 1_ff lat=8", c, s[7:0], lat);
    end
  endtask

  task automatic test_ignore_start();
    logic [12:0] s; logic c; int lat, bc;
    int ndone, dpos;
    logic [7:0] held, dsum;
    logic dcout;
    run_op(1'b0, 13'h0A, 13'h0B, 1'b0, s, c, lat, bc);
    vectors++;
    if (s[7:0] !== 8'h15 || c !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_op: got %b_%h expected 0_15", c, s[7:0]);
    end
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; dpos = -1; dsum = '0; dcout = 1'b0; held = sum8;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0;
        held = sum8;
      end
      if (n == 3) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (dpos < 0) begin dpos = n; dsum = sum8; dcout = cout8; end
      end
    end
    vectors++;
    if (held !== 8'h15) begin
      miscompares++;
      $display("FAIL sum_held_in_run: got %h expected 15", held);
    end
    vectors++;
    if (ndone != 1 || dpos != 8 || dsum !== 8'h47 || dcout !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: got pulses=%0d at=%0d res=%b_%h expected pulses=1 at=8 res=0_47",
               ndone, dpos, dcout, dsum);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [7:0] s1, s2;
    logic busy_after;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; busy_after = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (d1 > 0 && n == d1 + 1) begin
        busy_after = busy8;
        start8 = 1'b0;
      end
      if (done8) begin
        if (d1 < 0) begin
          d1 = n; s1 = sum8;
          a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        end else if (d2 < 0) begin
          d2 = n; s2 = sum8;
        end
      end
    end
    start8 = 1'b0;
    vectors++;
    if (d1 != 8 || s1 !== 8'h31) begin
      miscompares++;
      $display("FAIL b2b_first: got at=%0d sum=%h expected at=8 sum=31", d1, s1);
    end
    vectors++;
    if (busy_after !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_rerun: got busy=%b expected 1", busy_after);
    end
    vectors++;
    if (d2 < 0 || d2 - d1 != 9 || s2 !== 8'h03) begin
      miscompares++;
      $display("FAIL b2b_second: got gap=%0d sum=%h expected gap=9 sum=03", d2 - d1, s2);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({sum8, cout8, busy8, done8} !== 11'h0) begin
      miscompares++;
      $display("FAIL async_reset: got sum=%h cout=%b busy=%b done=%b expected all 0", sum8, cout8, busy8, done8);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done8 || busy8 || sum8 !== 8'h00) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL post_abort: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_random(input bit w13, input int count);
    logic [12:0] s, av, bv;
    logic c, ci;
    logic [13:0] ref_sum;
    int lat, bc, wd;
    wd = w13 ? 13 : 8;
    for (int i = 0; i < count; i++) begin
      av = 13'($urandom); bv = 13'($urandom); ci = 1'($urandom);
      if (!w13) begin av[12:8] = '0; bv[12:8] = '0; end
      if (i == 0) begin av = 13'((1 << wd) - 1); bv = av; ci = 1'b1; end
      ref_sum = 14'(av) + 14'(bv) + 14'(ci);
      run_op(w13, av, bv, ci, s, c, lat, bc);
      vectors++;
      if ((w13 ? {c, s} : {5'b0, c, s[7:0]}) !== (w13 ? ref_sum : {5'b0, ref_sum[8:0]}) || lat != wd) begin
        miscompares++;
        $display("FAIL random_w%0d: a=%h b=%h cin=%b got %b_%h lat=%0d expected %h lat=%0d",
                 wd, av, bv, ci, c, s, lat, ref_sum, wd);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
